// File: rtl/cpu_step_pkg.sv
// Shared state encodings and mode constants for the CPU run/step controller.
package cpu_step_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SLOW = 3'd1,
    S_FULL = 3'd2,
    S_STEP = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [1:0] MODE_HALT = 2'b00;
  localparam logic [1:0] MODE_SLOW = 2'b01;
  localparam logic [1:0] MODE_FULL = 2'b10;
  localparam logic [1:0] MODE_STEP = 2'b11;

  // Running state that a given mode selects; halt maps back to idle.
  function automatic state_t mode_to_state(input logic [1:0] mode);
    case (mode)
      MODE_SLOW: mode_to_state = S_SLOW;
      MODE_FULL: mode_to_state = S_FULL;
      MODE_STEP: mode_to_state = S_STEP;
      default:   mode_to_state = S_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/cpu_step_ctrl_btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stable-level debounce counter
// and rising-edge detect on the accepted level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DB_W            = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic db_level,
  output logic db_rise
);

  logic            sync_q1;
  logic            sync_q2;
  logic            db_level_d;
  logic [DB_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
    end
  end

  // The level is accepted only after it has differed for DEBOUNCE_CYCLES in a row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      db_level   <= 1'b0;
      db_level_d <= 1'b0;
    end else begin
      db_level_d <= db_level;
      if (sync_q2 == db_level) begin
        cnt <= '0;
      end else if (cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        db_level <= sync_q2;
        cnt      <= '0;
      end else begin
        cnt <= cnt + DB_W'(1);
      end
    end
  end

  assign db_rise = db_level & ~db_level_d;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Run/step controller: turns slow tick, debounced button and mode select into
// a single-cycle CPU clock-enable in the clk domain, and counts enabled cycles.
module cpu_step_ctrl
  import cpu_step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DB_W            = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        slow_tick_in,
  input  logic        step_btn,
  input  logic [1:0]  mode,
  input  logic        cpu_halted,
  output logic        cpu_en,
  output logic [15:0] step_count,
  output logic [2:0]  ctrl_state
);

  state_t state;
  state_t next_state;
  logic   tick_d;
  logic   tick_rise;
  logic   btn_level;
  logic   btn_edge;
  logic   btn_rise;
  logic   en_next;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DB_W           (DB_W)
  ) u_btn_debounce (
    .clk     (clk),
    .rst     (rst),
    .raw     (step_btn),
    .db_level(btn_level),
    .db_rise (btn_edge)
  );

  assign btn_rise  = btn_edge & btn_level;
  assign tick_rise = slow_tick_in & ~tick_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      tick_d     <= 1'b0;
      cpu_en     <= 1'b0;
      step_count <= '0;
    end else begin
      state  <= next_state;
      tick_d <= slow_tick_in;
      cpu_en <= en_next;
      if (cpu_en) step_count <= step_count + 16'd1;
    end
  end

  always_comb begin
    next_state = state;
    en_next    = 1'b0;
    case (state)
      S_IDLE: next_state = mode_to_state(mode);
      S_SLOW, S_FULL, S_STEP: begin
        if (cpu_halted) next_state = S_DONE;
        else            next_state = mode_to_state(mode);
      end
      S_DONE: if (mode == MODE_HALT) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase

    case (state)
      S_SLOW:  en_next = tick_rise;
      S_FULL:  en_next = 1'b1;
      S_STEP:  en_next = btn_rise;
      default: en_next = 1'b0;
    endcase
    // A transition cycle or a halted CPU never gets an enable.
    if (cpu_halted || (next_state != state)) en_next = 1'b0;
  end

  assign ctrl_state = state;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl with a 4-cycle debounce window.
module tb_cpu_step_ctrl;

  logic        clk;
  logic        rst;
  logic        slow_tick_in;
  logic        step_btn;
  logic [1:0]  mode;
  logic        cpu_halted;
  logic        cpu_en;
  logic [15:0] step_count;
  logic [2:0]  ctrl_state;

  int total;
  int bad;

  cpu_step_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .DB_W           (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .slow_tick_in(slow_tick_in),
    .step_btn    (step_btn),
    .mode        (mode),
    .cpu_halted  (cpu_halted),
    .cpu_en      (cpu_en),
    .step_count  (step_count),
    .ctrl_state  (ctrl_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are observed 1 ns after each rising edge.
  task automatic wait_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    slow_tick_in = 1'b0;
    step_btn     = 1'b0;
    mode         = 2'b00;
    cpu_halted   = 1'b0;
    wait_edge();
    wait_edge();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (cpu_en !== 1'b0) begin bad++; $display("FAIL reset_en: got %0b want 0", cpu_en); end
    total++; if (step_count !== 16'd0) begin bad++; $display("FAIL reset_count: got %0h want 0", step_count); end
    total++; if (ctrl_state !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", ctrl_state); end
    mode = 2'b10;
    for (int i = 0; i < 4; i++) wait_edge();
    total++; if (cpu_en !== 1'b1) begin bad++; $display("FAIL pre_reset_en: got %0b want 1", cpu_en); end
    rst = 1'b1;
    #1;
    total++; if (cpu_en !== 1'b0) begin bad++; $display("FAIL midreset_en: got %0b want 0", cpu_en); end
    total++; if (step_count !== 16'd0) begin bad++; $display("FAIL midreset_count: got %0h want 0", step_count); end
    total++; if (ctrl_state !== 3'd0) begin bad++; $display("FAIL midreset_state: got %0d want 0", ctrl_state); end
    wait_edge();
    rst = 1'b0;
    wait_edge();
    total++; if (ctrl_state !== 3'd2 || cpu_en !== 1'b0) begin bad++; $display("FAIL post_reset_first: state %0d en %0b want 2/0", ctrl_state, cpu_en); end
    wait_edge();
    total++; if (cpu_en !== 1'b1) begin bad++; $display("FAIL post_reset_second: got %0b want 1", cpu_en); end
    mode = 2'b00;
    wait_edge();
    total++; if (ctrl_state !== 3'd0 || cpu_en !== 1'b0) begin bad++; $display("FAIL full_to_idle: state %0d en %0b want 0/0", ctrl_state, cpu_en); end
  endtask

  task automatic test_slow_run();
    logic exp;
    do_reset();
    mode = 2'b01;
    wait_edge();
    total++; if (ctrl_state !== 3'd1 || cpu_en !== 1'b0) begin bad++; $display("FAIL slow_entry: state %0d en %0b want 1/0", ctrl_state, cpu_en); end
    for (int i = 0; i < 48; i++) begin
      slow_tick_in = ((i / 8) % 2) == 1;
      exp = (i == 8) || (i == 24) || (i == 40);
      wait_edge();
      total++; if (cpu_en !== exp) begin bad++; $display("FAIL slow_pulse[%0d]: got %0b want %0b", i, cpu_en, exp); end
    end
    wait_edge();
    total++; if (step_count !== 16'd3) begin bad++; $display("FAIL slow_count: got %0d want 3", step_count); end
  endtask

  task automatic test_step();
    logic pattern [0:31];
    logic exp;
    do_reset();
    mode = 2'b11;
    wait_edge();
    total++; if (ctrl_state !== 3'd3) begin bad++; $display("FAIL step_entry: got %0d want 3", ctrl_state); end
    for (int i = 0; i < 32; i++) pattern[i] = (i < 8) ? (((i / 2) % 2) == 0) : (i < 18);
    for (int i = 0; i < 32; i++) begin
      step_btn = pattern[i];
      exp = (i == 14);
      wait_edge();
      total++; if (cpu_en !== exp) begin bad++; $display("FAIL step_pulse[%0d]: got %0b want %0b", i, cpu_en, exp); end
    end
    total++; if (step_count !== 16'd1) begin bad++; $display("FAIL step_count: got %0d want 1", step_count); end
  endtask

  task automatic test_full_halt();
    do_reset();
    mode = 2'b10;
    for (int i = 0; i <= 20; i++) begin
      wait_edge();
      total++; if (cpu_en !== (i >= 1)) begin bad++; $display("FAIL full_en[%0d]: got %0b want %0b", i, cpu_en, (i >= 1)); end
    end
    cpu_halted = 1'b1;
    wait_edge();
    total++; if (cpu_en !== 1'b0) begin bad++; $display("FAIL halt_en: got %0b want 0", cpu_en); end
    total++; if (ctrl_state !== 3'd4) begin bad++; $display("FAIL halt_state: got %0d want 4", ctrl_state); end
    total++; if (step_count !== 16'd20) begin bad++; $display("FAIL full_count: got %0d want 20", step_count); end
    cpu_halted = 1'b0;
    mode = 2'b11;
    wait_edge();
    wait_edge();
    total++; if (ctrl_state !== 3'd4 || cpu_en !== 1'b0) begin bad++; $display("FAIL done_hold: state %0d en %0b want 4/0", ctrl_state, cpu_en); end
    mode = 2'b00;
    wait_edge();
    total++; if (ctrl_state !== 3'd0) begin bad++; $display("FAIL done_exit: got %0d want 0", ctrl_state); end
  endtask

  task automatic test_wrap();
    do_reset();
    mode = 2'b10;
    for (int n = 1; n <= 65539; n++) begin
      wait_edge();
      if (n == 65537) begin
        total++; if (step_count !== 16'hFFFF) begin bad++; $display("FAIL wrap_max: got %0h want ffff", step_count); end
      end
      if (n == 65538) begin
        total++; if (step_count !== 16'h0000) begin bad++; $display("FAIL wrap_zero: got %0h want 0", step_count); end
      end
    end
    total++; if (step_count !== 16'h0001) begin bad++; $display("FAIL wrap_one: got %0h want 1", step_count); end
  endtask

  task automatic test_collisions();
    do_reset();
    mode = 2'b01;
    wait_edge();
    slow_tick_in = 1'b1;
    mode = 2'b10;
    wait_edge();
    total++; if (ctrl_state !== 3'd2 || cpu_en !== 1'b0) begin bad++; $display("FAIL switch_edge: state %0d en %0b want 2/0", ctrl_state, cpu_en); end
    wait_edge();
    total++; if (cpu_en !== 1'b1) begin bad++; $display("FAIL switch_full: got %0b want 1", cpu_en); end

    do_reset();
    mode = 2'b01;
    wait_edge();
    slow_tick_in = 1'b1;
    cpu_halted = 1'b1;
    wait_edge();
    total++; if (cpu_en !== 1'b0 || ctrl_state !== 3'd4) begin bad++; $display("FAIL halt_edge: en %0b state %0d want 0/4", cpu_en, ctrl_state); end
    wait_edge();
    total++; if (cpu_en !== 1'b0) begin bad++; $display("FAIL halt_edge_late: got %0b want 0", cpu_en); end

    do_reset();
    slow_tick_in = 1'b1;
    wait_edge();
    wait_edge();
    mode = 2'b01;
    for (int i = 0; i < 4; i++) begin
      wait_edge();
      total++; if (cpu_en !== 1'b0) begin bad++; $display("FAIL high_entry[%0d]: got %0b want 0", i, cpu_en); end
    end
    slow_tick_in = 1'b0;
    wait_edge();
    slow_tick_in = 1'b1;
    wait_edge();
    total++; if (cpu_en !== 1'b1) begin bad++; $display("FAIL true_rise: got %0b want 1", cpu_en); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst          = 1'b1;
    slow_tick_in = 1'b0;
    step_btn     = 1'b0;
    mode         = 2'b00;
    cpu_halted   = 1'b0;
    test_reset();
    test_slow_run();
    test_step();
    test_full_halt();
    test_collisions();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
